conv_mcif_wr: RTL and testbench

- Write-path bridge between the conv write-DMA request stream and the AXI4 master write channels (AW/W/B).
- Consumes the packed command/data request stream, which is one command word followed by length+1 data words per burst.
- Issues one AXI burst per command and tracks outstanding bursts.
- Returns a one-cycle completion pulse when the final (nonposted) burst of a layer has been acknowledged.

---
 rtl/conv_mcif_wr.sv | 171 +++++++++++++++++
 tb/tb_conv_mcif_wr.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mcif_wr.sv
// conv_mcif_wr: write-path bridge from the conv write-DMA request stream to
// the AXI4 write channels (AW/W/B).
//
// The request stream carries one command word (pd[PD_W-1]=1) followed by
// length+1 data words. Each command becomes one INCR burst. Data words pass
// straight through to W with no buffering. AW is issued from a registered
// copy of the command and may lag W.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   wr_req_vld/rdy/pd     packed command/data request stream
//   wr_rsp_complete       one-cycle pulse: last nonposted burst acknowledged
//   aw*/w*/b*             AXI4 master write channels
//   err_sticky            protocol/response error flag, cleared by reset only
module conv_mcif_wr #(
    parameter int DW     = 256,
    parameter int LEN_W  = 4,
    parameter int MAX_OS = 8,
    localparam int PD_W  = 2 + LEN_W + 32 + DW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_req_vld,
    output logic              wr_req_rdy,
    input  logic [PD_W-1:0]   wr_req_pd,
    output logic              wr_rsp_complete,
    output logic              awvalid,
    input  logic              awready,
    output logic [31:0]       awaddr,
    output logic [7:0]        awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic              wvalid,
    input  logic              wready,
    output logic [DW-1:0]     wdata,
    output logic [DW/8-1:0]   wstrb,
    output logic              wlast,
    input  logic              bvalid,
    output logic              bready,
    input  logic [1:0]        bresp,
    output logic              err_sticky
);
    localparam int OS_W = $clog2(MAX_OS) + 1;

    typedef enum logic {IDLE, DATA} state_t;

    state_t            state;
    logic              aw_pend;
    logic              np_cur;
    logic              np_pend;
    logic              complete_r;
    logic              err_r;
    logic [31:0]       awaddr_r;
    logic [7:0]        awlen_r;
    logic [LEN_W-1:0]  beat_cnt;
    logic [OS_W-1:0]   os_cnt;

    // Command word fields
    logic              is_cmd;
    logic [31:0]       cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              cmd_np;
    logic [31:0]       cmd_base;
    logic              unused_pd;

    assign is_cmd    = wr_req_pd[PD_W-1];
    assign cmd_addr  = wr_req_pd[31:0];
    assign cmd_len   = wr_req_pd[LEN_W+31:32];
    assign cmd_np    = wr_req_pd[LEN_W+32];
    assign cmd_base  = wr_req_pd[LEN_W+64:LEN_W+33];
    assign unused_pd = ^wr_req_pd[PD_W-2:DW];

    logic in_data;
    logic req_hs, cmd_hs, idle_drop, bad_cmd, w_hs;
    logic aw_hs, b_hs, b_eff, last_beat;

    assign in_data = (state == DATA);

    // IDLE: commands gated by outstanding limit and a still-pending AW; stray
    // data words are always swallowed so the stream cannot wedge.
    // DATA: ready follows W; a command word is held off until the burst ends.
    always_comb begin
        wr_req_rdy = 1'b0;
        if (!in_data)
            wr_req_rdy = is_cmd ? ((os_cnt < OS_W'(MAX_OS)) && !aw_pend) : 1'b1;
        else
            wr_req_rdy = wready && !is_cmd;
    end

    assign req_hs    = wr_req_vld && wr_req_rdy;
    assign cmd_hs    = req_hs && is_cmd && !in_data;
    assign idle_drop = req_hs && !is_cmd && !in_data;
    assign bad_cmd   = wr_req_vld && is_cmd && in_data;
    assign w_hs      = in_data && wr_req_vld && !is_cmd && wready;
    assign aw_hs     = aw_pend && awready;
    assign b_hs      = bvalid;
    // A B with nothing outstanding is ignored (and flagged below)
    assign b_eff     = b_hs && (os_cnt != '0);
    assign last_beat = (beat_cnt == awlen_r[LEN_W-1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            aw_pend    <= 1'b0;
            np_cur     <= 1'b0;
            np_pend    <= 1'b0;
            complete_r <= 1'b0;
            err_r      <= 1'b0;
            awaddr_r   <= '0;
            awlen_r    <= '0;
            beat_cnt   <= '0;
            os_cnt     <= '0;
        end else begin
            if (aw_hs)
                aw_pend <= 1'b0;

            case (state)
                IDLE: begin
                    if (cmd_hs) begin
                        awaddr_r <= cmd_base + cmd_addr;
                        awlen_r  <= 8'(cmd_len);
                        np_cur   <= cmd_np;
                        aw_pend  <= 1'b1;
                        beat_cnt <= '0;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (w_hs) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (last_beat)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            case ({aw_hs, b_eff})
                2'b10:   os_cnt <= os_cnt + 1'b1;
                2'b01:   os_cnt <= os_cnt - 1'b1;
                default: ;
            endcase

            // Completion fires only when the outstanding count drains to zero
            // with no new AW slipping in during the same cycle.
            complete_r <= np_pend && b_eff && (os_cnt == OS_W'(1)) && !aw_hs;
            if (aw_hs && np_cur)
                np_pend <= 1'b1;
            else if (np_pend && b_eff && (os_cnt == OS_W'(1)) && !aw_hs)
                np_pend <= 1'b0;

            if (idle_drop || bad_cmd || (b_hs && (os_cnt == '0)) ||
                (b_hs && (bresp != 2'b00)))
                err_r <= 1'b1;
        end
    end

    assign awvalid         = aw_pend;
    assign awaddr          = awaddr_r;
    assign awlen           = awlen_r;
    assign awsize          = 3'($clog2(DW/8));
    assign awburst         = 2'b01;
    assign wvalid          = in_data && wr_req_vld && !is_cmd;
    assign wdata           = wr_req_pd[DW-1:0];
    assign wstrb           = '1;
    assign wlast           = in_data && last_beat;
    assign bready          = 1'b1;
    assign wr_rsp_complete = complete_r;
    assign err_sticky      = err_r;

endmodule

// File: tb/tb_conv_mcif_wr.sv
// tb_conv_mcif_wr: directed self-checking bench for conv_mcif_wr.
// A driver feeds command/data words, a posedge monitor scores W data, wlast
// and AW stability against queues filled by the driver, and a B responder
// returns one response per burst a fixed delay after its last beat.
module tb_conv_mcif_wr;
    localparam int DW     = 256;
    localparam int LEN_W  = 4;
    localparam int MAX_OS = 8;
    localparam int PD_W   = 2 + LEN_W + 32 + DW;

    logic              clk;
    logic              rst_n;
    logic              wr_req_vld;
    logic              wr_req_rdy;
    logic [PD_W-1:0]   wr_req_pd;
    logic              wr_rsp_complete;
    logic              awvalid, awready;
    logic [31:0]       awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              wvalid, wready;
    logic [DW-1:0]     wdata;
    logic [DW/8-1:0]   wstrb;
    logic              wlast;
    logic              bvalid, bready;
    logic [1:0]        bresp;
    logic              err_sticky;

    conv_mcif_wr #(.DW(DW), .LEN_W(LEN_W), .MAX_OS(MAX_OS)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_req_vld(wr_req_vld), .wr_req_rdy(wr_req_rdy), .wr_req_pd(wr_req_pd),
        .wr_rsp_complete(wr_rsp_complete),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .err_sticky(err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(string tag, logic [255:0] got, logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ---------------- monitor / scoreboard ----------------
    int cyc = 0;
    int aw_cnt, cmp_cnt, cmp_cyc, b_cyc, os_mdl, os_peak, beat;
    bit exp_last, aw_wait;
    logic [39:0]  aw_prev;
    logic [31:0]  aw_addr_q[$];
    logic [7:0]   aw_len_q[$];
    int           wl_q[$];
    int           len_q[$];
    logic [255:0] exp_d[$];

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            aw_cnt = 0; cmp_cnt = 0; cmp_cyc = 0; b_cyc = 0;
            os_mdl = 0; os_peak = 0; beat = 0; aw_wait = 0;
            aw_addr_q.delete(); aw_len_q.delete(); wl_q.delete();
            len_q.delete(); exp_d.delete();
        end else begin
            if (aw_wait) begin
                check("aw_hold", awvalid, 1);
                check("aw_stable", {awaddr, awlen}, aw_prev);
            end
            aw_wait = awvalid && !awready;
            aw_prev = {awaddr, awlen};
            if (awvalid && awready) begin
                aw_cnt++; os_mdl++;
                aw_addr_q.push_back(awaddr);
                aw_len_q.push_back(awlen);
            end
            if (bvalid && os_mdl > 0) begin
                os_mdl--; b_cyc = cyc;
            end
            if (os_mdl > os_peak) os_peak = os_mdl;
            if (wr_rsp_complete) begin
                cmp_cnt++; cmp_cyc = cyc;
            end
            if (wvalid && wready) begin
                if (exp_d.size() == 0) check("w_extra", 1, 0);
                else check("wdata", wdata, exp_d.pop_front());
                exp_last = (len_q.size() > 0) && (beat == len_q[0]);
                check("wlast", wlast, exp_last);
                if (exp_last) begin
                    beat = 0;
                    void'(len_q.pop_front());
                    wl_q.push_back(cyc);
                end else begin
                    beat++;
                end
            end
        end
    end

    // ---------------- B responder ----------------
    int b_sent = 0;
    int b_delay = 5;
    int err_idx = -1;
    bit b_en = 1'b1;

    initial begin
        bvalid = 1'b0; bresp = 2'b00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bvalid = 1'b0; bresp = 2'b00; b_sent = 0;
            end else if (b_en && aw_cnt > b_sent && wl_q.size() > b_sent &&
                         cyc >= wl_q[b_sent] + b_delay) begin
                bvalid = 1'b1;
                bresp  = (b_sent == err_idx) ? 2'b10 : 2'b00;
                b_sent++;
            end else begin
                bvalid = 1'b0; bresp = 2'b00;
            end
        end
    end

    // ---------------- ready generator ----------------
    bit rnd_rdy = 1'b0;
    initial begin
        awready = 1'b1; wready = 1'b1;
        forever begin
            @(negedge clk);
            awready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            wready  = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ---------------- driver helpers ----------------
    function automatic logic [PD_W-1:0] mk_cmd(logic [31:0] base, logic [31:0] addr,
                                               int len, logic np);
        logic [PD_W-1:0] pd;
        pd = '0;
        pd[PD_W-1]              = 1'b1;
        pd[31:0]                = addr;
        pd[LEN_W+31:32]         = LEN_W'(len);
        pd[LEN_W+32]            = np;
        pd[LEN_W+64:LEN_W+33]   = base;
        return pd;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] d;
        for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_word(logic [PD_W-1:0] pd);
        bit ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            wr_req_vld = 1'b1;
            wr_req_pd  = pd;
            #1 ok = wr_req_rdy;
            @(posedge clk);
        end
        if (!ok) check("hs_timeout", 0, 1);
    endtask

    task automatic send_data();
        logic [255:0]    d;
        logic [PD_W-1:0] pd;
        d = rand256();
        pd = '0;
        pd[DW-1:0] = d;
        exp_d.push_back(d);
        send_word(pd);
    endtask

    task automatic send_burst(logic [31:0] base, logic [31:0] addr, int len, logic np);
        len_q.push_back(len);
        send_word(mk_cmd(base, addr, len, np));
        for (int b = 0; b <= len; b++) send_data();
    endtask

    task automatic idle();
        @(negedge clk);
        wr_req_vld = 1'b0;
    endtask

    task automatic wait_bs(int n, int max);
        int i = 0;
        while (b_sent < n && i < max) begin
            @(posedge clk);
            i++;
        end
        check("b_done", b_sent, n);
        tick(3);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        wr_req_vld = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- directed tests ----------------
    initial begin
        rst_n = 1'b0;
        wr_req_vld = 1'b0;
        wr_req_pd = '0;
        do_reset();
        #1;
        check("rst_outs", {awvalid, wvalid, wlast, wr_rsp_complete, err_sticky, bready}, 6'b000001);
        check("rst_aw", {awaddr, awlen}, 40'h0);
        check("rst_awsize", awsize, 3'd5);
        check("rst_awburst", awburst, 2'b01);
        check("rst_wstrb", wstrb, 32'hFFFF_FFFF);

        // single burst
        b_delay = 5;
        send_burst(32'h1000_0000, 32'h40, 3, 1'b1);
        idle();
        wait_bs(1, 100);
        check("t1_aw_cnt", aw_cnt, 1);
        check("t1_awaddr", aw_addr_q[0], 32'h1000_0040);
        check("t1_awlen", aw_len_q[0], 8'd3);
        check("t1_cmp_cnt", cmp_cnt, 1);
        check("t1_cmp_lat", cmp_cyc - b_cyc, 1);
        check("t1_drain", exp_d.size(), 0);

        // back-to-back, only the last burst nonposted
        do_reset();
        b_delay = 20;
        send_burst(32'h0, 32'h000, 15, 1'b0);
        send_burst(32'h0, 32'h200, 15, 1'b0);
        send_burst(32'h0, 32'h400, 15, 1'b1);
        idle();
        wait_bs(3, 300);
        check("t2_os_peak", os_peak, 3);
        check("t2_cmp_cnt", cmp_cnt, 1);
        check("t2_cmp_lat", cmp_cyc - b_cyc, 1);
        check("t2_awaddr3", aw_addr_q[2], 32'h400);
        check("t2_err", err_sticky, 0);

        // random backpressure on AW and W
        do_reset();
        rnd_rdy = 1'b1;
        b_delay = 2;
        for (int i = 0; i < 10; i++)
            send_burst(32'h2000_0000, 32'(i * 64), (i * 5) % 16, i == 9);
        idle();
        wait_bs(10, 3000);
        rnd_rdy = 1'b0;
        check("t3_data_left", exp_d.size(), 0);
        check("t3_len_left", len_q.size(), 0);
        check("t3_aw_cnt", aw_cnt, 10);
        check("t3_awaddr9", aw_addr_q[9], 32'h2000_0240);
        check("t3_cmp_cnt", cmp_cnt, 1);
        check("t3_err", err_sticky, 0);

        // outstanding limit
        do_reset();
        b_en = 1'b0;
        b_delay = 2;
        for (int i = 0; i < 8; i++) send_burst(32'h3000_0000, 32'(i * 4), 0, 1'b0);
        @(negedge clk);
        wr_req_vld = 1'b1;
        wr_req_pd  = mk_cmd(32'h3000_0000, 32'h20, 0, 1'b0);
        #1 check("t4_rdy_full0", wr_req_rdy, 0);
        repeat (10) @(negedge clk);
        #1;
        check("t4_rdy_full1", wr_req_rdy, 0);
        check("t4_os_max", os_mdl, 8);
        b_en = 1'b1;
        send_burst(32'h3000_0000, 32'h20, 0, 1'b0);
        send_burst(32'h3000_0000, 32'h24, 0, 1'b1);
        idle();
        wait_bs(10, 500);
        check("t4_aw_cnt", aw_cnt, 10);
        check("t4_cmp_cnt", cmp_cnt, 1);
        check("t4_err", err_sticky, 0);

        // error response on burst 2, sticky until reset
        do_reset();
        b_delay = 3;
        err_idx = 1;
        send_burst(32'h0, 32'h100, 1, 1'b0);
        idle();
        wait_bs(1, 100);
        check("t5_err_before", err_sticky, 0);
        send_burst(32'h0, 32'h140, 1, 1'b0);
        idle();
        wait_bs(2, 100);
        err_idx = -1;
        check("t5_err_bresp", err_sticky, 1);
        tick(20);
        check("t5_err_held", err_sticky, 1);
        do_reset();
        #1 check("t5_err_rst", err_sticky, 0);

        // stray data word in IDLE is dropped and flagged
        @(negedge clk);
        wr_req_vld = 1'b1;
        wr_req_pd  = '0;
        wr_req_pd[31:0] = 32'hDEAD_BEEF;
        #1;
        check("t5_drop_rdy", wr_req_rdy, 1);
        check("t5_drop_nowv", wvalid, 0);
        idle();
        tick(1);
        check("t5_err_drop", err_sticky, 1);

        // reset in the middle of a burst
        do_reset();
        b_delay = 3;
        len_q.push_back(3);
        send_word(mk_cmd(32'h4000_0000, 32'h0, 3, 1'b1));
        send_data();
        send_data();
        @(negedge clk);
        rst_n = 1'b0;
        wr_req_vld = 1'b0;
        #1;
        check("t6_rst_outs", {awvalid, wvalid, wlast, wr_rsp_complete, err_sticky, bready}, 6'b000001);
        check("t6_rst_aw", {awaddr, awlen}, 40'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_burst(32'h4000_0000, 32'h80, 3, 1'b1);
        idle();
        wait_bs(1, 100);
        check("t6_awaddr", aw_addr_q[0], 32'h4000_0080);
        check("t6_cmp_cnt", cmp_cnt, 1);
        check("t6_drain", exp_d.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
